dmem_responder: RTL and testbench

//  Responder side of the CPU MEM-stage data-memory interface: a multi-cycle data memory with req/ack handshake.

---
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: responder side of the MEM-stage data-memory handshake.
// One word request at a time is accepted, serviced after LATENCY cycles and
// completed with a one-cycle ack. stall_o freezes the pipeline meanwhile.
// Optional feature: define MISALIGN_TRAP_EN to turn non-word-aligned
// addresses into error responses (no memory access, err_o with ack).
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        ready_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [7:0]         cnt_q;
    logic               we_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic               accept;
    logic               access;
    logic               misaligned;

    logic [31:0]        mem [DEPTH_WORDS];

`ifdef MISALIGN_TRAP_EN
    logic               mis_q;
    logic               unused_addr_bits;

    // Misaligned flag is captured with the request and steers the response.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mis_q <= (addr_i[1:0] != 2'b00);
        end
    end

    assign misaligned       = mis_q;
    assign err_o            = (state_q == RESP) && mis_q;
    assign unused_addr_bits = ^addr_i[31:IDX_W+2];
`else
    logic               unused_addr_bits;

    // Byte offset and bits above the word index never affect the access.
    assign misaligned       = 1'b0;
    assign err_o            = 1'b0;
    assign unused_addr_bits = ^{addr_i[31:IDX_W+2], addr_i[1:0]};
`endif

    // Handshake strobes: a request is taken only in IDLE; the access edge is
    // the WAIT edge where the countdown has reached zero. Reset wins over both.
    assign accept = (state_q == IDLE) && req_i && !rst_i;
    assign access = (state_q == WAIT) && (cnt_q == 8'd0) && !rst_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the IDLE -> WAIT -> RESP -> IDLE cycle.
    always_comb begin
        // NOTE: assigning the default first keeps every path driven, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_i) state_d = WAIT;
            WAIT:    if (cnt_q == 8'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; stall drops in RESP so the requester advances with ack.
    assign ready_o = (state_q == IDLE);
    assign ack_o   = (state_q == RESP);
    assign stall_o = ((state_q == IDLE) && req_i && !rst_i) || (state_q == WAIT);

    // Request capture, latency countdown and load-data register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            cnt_q   <= 8'd0;
            rdata_o <= 32'd0;
        end else begin
            if (accept) begin
                we_q    <= we_i;
                idx_q   <= addr_i[IDX_W+1:2];
                wdata_q <= wdata_i;
                be_q    <= be_i;
                cnt_q   <= 8'(LATENCY - 1);
            end else if ((state_q == WAIT) && (cnt_q != 8'd0)) begin
                cnt_q <= cnt_q - 8'd1;
            end

            if (access) begin
                if (misaligned) begin
                    rdata_o <= 32'd0;
                end else if (!we_q) begin
                    rdata_o <= mem[idx_q];
                end
            end
        end
    end

    // Storage array: byte-enabled write on the access edge of a store.
    // NOTE: the array has no reset; clearing it would need a per-word reset tree.
    always_ff @(posedge clk_i) begin
        if (access && we_q && !misaligned) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH_WORDS=256, LATENCY=4).
// A transaction-level model tracks accept edges and memory contents; a
// compare process checks every output on every falling edge, and directed
// scenarios pin literal expectations. Honors MISALIGN_TRAP_EN if defined.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int L = 4;

    logic        clk_i   = 1'b0;
    logic        rst_i   = 1'b1;
    logic        req_i   = 1'b1;
    logic        we_i    = 1'b0;
    logic [31:0] addr_i  = 32'd0;
    logic [31:0] wdata_i = 32'd0;
    logic [3:0]  be_i    = 4'd0;
    logic        ready_o;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    dmem_responder #(
        .DEPTH_WORDS(256),
        .LATENCY    (L)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  (req_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .wdata_i(wdata_i),
        .be_i   (be_i),
        .ready_o(ready_o),
        .ack_o  (ack_o),
        .rdata_o(rdata_o),
        .stall_o(stall_o),
        .err_o  (err_o)
    );

    // ---------------- behavioural model ----------------
    int unsigned cyc = 0;          // number of rising edges seen
    bit          m_busy = 0;
    int unsigned m_acc = 0;        // edge number at which the request was taken
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_mem [256];
    bit          m_known [256];
    logic [31:0] m_rdata = 32'd0;
    bit          m_rknown = 1;
    bit          m_err = 0;

    function automatic bit is_mis(input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk_i) begin
        int unsigned ph;
        int          idx;
        cyc++;
        ph = cyc - m_acc;
        if (rst_i) begin
            m_busy   = 0;
            m_rdata  = 32'd0;
            m_rknown = 1;
            m_err    = 0;
        end else if (!m_busy) begin
            if (req_i) begin
                m_busy  = 1;
                m_acc   = cyc;
                m_we    = we_i;
                m_addr  = addr_i;
                m_wdata = wdata_i;
                m_be    = be_i;
            end
        end else if (ph == L) begin
            idx   = int'(m_addr[9:2]);
            m_err = is_mis(m_addr);
            if (m_err) begin
                m_rdata  = 32'd0;
                m_rknown = 1;
            end else if (m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) m_mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
                if (m_be == 4'hF) m_known[idx] = 1;
            end else begin
                m_rdata  = m_mem[idx];
                m_rknown = m_known[idx];
            end
        end else if (ph == L + 1) begin
            m_busy = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge clk_i) begin
        int unsigned ph;
        bit resp;
        bit wt;
        if (cyc >= 1) begin
            ph   = cyc - m_acc;
            resp = m_busy && (ph == L);
            wt   = m_busy && (ph < L);
            check("ready_o", 32'(ready_o), 32'(!m_busy));
            check("ack_o",   32'(ack_o),   32'(resp));
            check("stall_o", 32'(stall_o), 32'(wt || (!m_busy && req_i && !rst_i)));
            check("err_o",   32'(err_o),   32'(resp && m_err));
            if (m_rknown) check("rdata_o", rdata_o, m_rdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rd, output logic er);
        int unsigned acc;
        int          lat;
        @(posedge clk_i); #2;
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
        @(posedge clk_i); #1;
        acc = cyc;
        #1;
        lat = -1;
        rd  = 'x;
        er  = 'x;
        for (int i = 0; i < 20; i++) begin
            req_i   = (cyc < acc + L) ? 1'($urandom_range(0, 1)) : 1'b0;
            we_i    = 1'($urandom);
            addr_i  = $urandom;
            wdata_i = $urandom;
            be_i    = 4'($urandom);
            @(negedge clk_i);
            if (ack_o) begin
                lat = int'(cyc - acc);
                rd  = rdata_o;
                er  = err_o;
                break;
            end
            @(posedge clk_i); #2;
        end
        req_i = 1'b0;
        check("ack_latency", 32'(lat), 32'(L));
    endtask

    logic [31:0] rd;
    logic        er;
    logic [7:0]  pool [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: reset held with a pending request: idle outputs, nothing taken.
        repeat (2) begin
            @(negedge clk_i);
            check("t1_ready", 32'(ready_o), 32'd1);
            check("t1_ack",   32'(ack_o),   32'd0);
            check("t1_stall", 32'(stall_o), 32'd0);
            check("t1_rdata", rdata_o,      32'd0);
        end
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        req_i = 1'b0;

        // Test 2: full store then load.
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er);
        txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        check("t2_rdata", rd, 32'hDEADBEEF);

        // Test 3: partial byte store.
        txn(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er);
        txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
        check("t3_rdata", rd, 32'hDE22BE44);

        // Test 4: address wrap to word 0.
        txn(1'b1, 32'h400, 32'h5, 4'hF, rd, er);
        txn(1'b0, 32'h000, 32'h0, 4'h0, rd, er);
        check("t4_rdata", rd, 32'h00000005);

        // Empty byte-enable store leaves word 0 unchanged.
        txn(1'b1, 32'h0, 32'hFFFFFFFF, 4'b0000, rd, er);
        txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er);
        check("be0_rdata", rd, 32'h00000005);

        // Test 5: store aborted by reset in its second WAIT cycle.
        txn(1'b1, 32'h20, 32'h0, 4'hF, rd, er);
        @(posedge clk_i); #2;
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; wdata_i = 32'hCAFEF00D; be_i = 4'hF;
        @(posedge clk_i); #2;          // accepted; first WAIT cycle
        req_i = 1'b0;
        @(posedge clk_i); #2;          // second WAIT cycle
        rst_i = 1'b1;
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        begin
            bit saw_ack;
            saw_ack = 0;
            repeat (8) begin
                @(negedge clk_i);
                if (ack_o) saw_ack = 1;
            end
            check("t5_no_ack", 32'(saw_ack), 32'd0);
        end
        txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er);
        check("t5_rdata", rd, 32'h0);

        // Test 6: misaligned load.
        txn(1'b0, 32'h12, 32'h0, 4'h0, rd, er);
`ifdef MISALIGN_TRAP_EN
        check("t6_rdata", rd, 32'h0);
        check("t6_err", 32'(er), 32'd1);
`else
        check("t6_rdata", rd, 32'hDE22BE44);
        check("t6_err", 32'(er), 32'd0);
`endif

        // Randomized traffic over a pool of initialised words.
        for (int i = 0; i < 8; i++) begin
            pool[i] = 8'($urandom);
            txn(1'b1, {22'($urandom), pool[i], 2'b00}, $urandom, 4'hF, rd, er);
        end
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = {22'($urandom), pool[$urandom_range(0, 7)],
                 ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00};
            txn(1'($urandom), a, $urandom, 4'($urandom), rd, er);
        end

        repeat (2) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
